// File: rtl/add_word_sequencer.sv
// Multi-precision add/subtract sequencer for an external N-bit ripple-carry adder.
// Operand words stream in LSW first. The adder's carry-out is chained between
// words through carry_q. Each result word is held in a single output register.
module add_word_sequencer #(
   parameter int N     = 16,
   parameter int WORDS = 4,
   parameter int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_x,
   input  logic [N-1:0]  in_y,
   input  logic          in_first,
   input  logic          in_last,
   input  logic          in_sub,
   output logic          add_carryin,
   output logic [N-1:0]  add_X,
   output logic [N-1:0]  add_Y,
   input  logic [N-1:0]  add_S,
   input  logic          add_carryout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_s,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          out_carry,
   output logic          frame_err,
   output logic          seq_err
);

   localparam logic [IW-1:0] IDX_MAX = IW'(WORDS - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t        state, state_nxt;
   logic          carry_q;
   logic          sub_q;
   logic [IW-1:0] idx_q;
   logic          accept;
   logic          first;
   logic          eff_sub;
   logic [IW-1:0] idx_nxt;

   // Single output register: a new word can be taken when the register is empty
   // or is being drained in this same cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A word is first when no frame is open, or when in_first restarts the chain mid-frame.
   assign first    = (state == IDLE) || in_first;
   assign eff_sub  = first ? in_sub : sub_q;

   // Index of the next word. It saturates so that an overlong frame still reports a legal index.
   assign idx_nxt  = first ? '0 : ((idx_q == IDX_MAX) ? idx_q : idx_q + 1'b1);

   // Adder drive. Subtract is done as X + ~Y + 1, and the +1 enters on the first word only.
   always_comb begin
      add_X       = in_x;
      add_Y       = eff_sub ? ~in_y : in_y;
      add_carryin = first ? in_sub : carry_q;
   end

   // Frame state register
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic. Only an accepted word moves the FSM.
   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = in_last ? IDLE : ACTIVE;
   end

   // Carry chain and per-frame context. These registers hold while no word is accepted.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         carry_q <= add_carryout;
         idx_q   <= idx_nxt;
         if (first) sub_q <= in_sub;
      end
   end

   // Output register. It loads on accept, clears valid after a drain, and otherwise holds.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         out_valid <= 1'b0;
         out_s     <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         out_carry <= 1'b0;
         frame_err <= 1'b0;
         seq_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_s     <= add_S;
         out_idx   <= idx_nxt;
         out_last  <= in_last;
         out_carry <= add_carryout;
         frame_err <= !first && (idx_q == IDX_MAX);
         seq_err   <= (state == ACTIVE) && in_first;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_word_sequencer.sv
// Directed bench for add_word_sequencer. It includes a behavioural model of the
// external ripple-carry adder, and every expected value below was worked out by hand.
module tb_add_word_sequencer;

   localparam int N  = 16;
   localparam int IW = 2;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          in_valid, in_ready;
   logic [N-1:0]  in_x, in_y;
   logic          in_first, in_last, in_sub;
   logic          add_carryin;
   logic [N-1:0]  add_X, add_Y, add_S;
   logic          add_carryout;
   logic          out_valid, out_ready;
   logic [N-1:0]  out_s;
   logic [IW-1:0] out_idx;
   logic          out_last, out_carry, frame_err, seq_err;

   int total = 0;
   int bad   = 0;

   always #5 Clock = ~Clock;

   // The adder: combinational N-bit add with carry in and carry out.
   assign {add_carryout, add_S} = {1'b0, add_X} + {1'b0, add_Y} + {{N{1'b0}}, add_carryin};

   add_word_sequencer #(.N(N), .WORDS(4)) dut (
      .Clock(Clock), .Reset(Reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
      .add_carryin(add_carryin), .add_X(add_X), .add_Y(add_Y),
      .add_S(add_S), .add_carryout(add_carryout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_idx(out_idx), .out_last(out_last), .out_carry(out_carry),
      .frame_err(frame_err), .seq_err(seq_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one word, check the adder drive before the edge, then clock it in.
   task automatic send(input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic f, input logic l, input logic s,
                       input logic exp_cin, input string tag);
      in_x = x; in_y = y; in_first = f; in_last = l; in_sub = s; in_valid = 1'b1;
      #1;
      chk({tag, "_cin"}, 32'(add_carryin), 32'(exp_cin));
      @(posedge Clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic res(input string tag, input logic [N-1:0] s, input logic [IW-1:0] idx,
                      input logic l, input logic c, input logic fe, input logic se);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_s"},     32'(out_s),     32'(s));
      chk({tag, "_idx"},   32'(out_idx),   32'(idx));
      chk({tag, "_last"},  32'(out_last),  32'(l));
      chk({tag, "_carry"}, 32'(out_carry), 32'(c));
      chk({tag, "_ferr"},  32'(frame_err), 32'(fe));
      chk({tag, "_serr"},  32'(seq_err),   32'(se));
   endtask

   initial begin
      Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_x = '0; in_y = '0; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_s",     32'(out_s),     0);
      chk("rst_idx",   32'(out_idx),   0);
      chk("rst_last",  32'(out_last),  0);
      chk("rst_carry", 32'(out_carry), 0);
      chk("rst_ferr",  32'(frame_err), 0);
      chk("rst_serr",  32'(seq_err),   0);
      chk("rst_ready", 32'(in_ready),  1);
      Reset = 1'b0;
      @(posedge Clock); #1;

      // Add: 0x0001_FFFF + 0x0000_0001 = 0x0002_0000
      send(16'hFFFF, 16'h0001, 1, 0, 0, 0, "add0"); res("add0", 16'h0000, 0, 0, 1, 0, 0);
      send(16'h0001, 16'h0000, 0, 1, 0, 1, "add1"); res("add1", 16'h0002, 1, 1, 0, 0, 0);
      @(posedge Clock); #1;
      chk("drain_valid", 32'(out_valid), 0);

      // Subtract 0 - 1: borrow all the way, so the final carry is 0. in_sub=0 on word1 must be ignored.
      send(16'h0000, 16'h0001, 1, 0, 1, 1, "sub0");
      chk("sub0_addY", 32'(add_Y), 32'h0000_FFFE);
      res("sub0", 16'hFFFF, 0, 0, 0, 0, 0);
      send(16'h0000, 16'h0000, 0, 1, 0, 0, "sub1"); res("sub1", 16'hFFFF, 1, 1, 0, 0, 0);
      // Subtract 5 - 3 = 2, no borrow
      send(16'h0005, 16'h0003, 1, 0, 1, 1, "subb0"); res("subb0", 16'h0002, 0, 0, 1, 0, 0);
      send(16'h0000, 16'h0000, 0, 1, 1, 1, "subb1"); res("subb1", 16'h0000, 1, 1, 1, 0, 0);

      // Backpressure: 0x0001_0003_FFFF + 0x0001_0002_0001
      send(16'hFFFF, 16'h0001, 1, 0, 0, 0, "bp0"); res("bp0", 16'h0000, 0, 0, 1, 0, 0);
      out_ready = 1'b0;
      in_x = 16'h0003; in_y = 16'h0002; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", 32'(in_ready),  0);
         chk("bp_s",     32'(out_s),     32'h0);
         chk("bp_idx",   32'(out_idx),   0);
         chk("bp_cin",   32'(add_carryin), 1);
         @(posedge Clock); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(in_ready), 1);
      @(posedge Clock); #1;
      in_valid = 1'b0;
      res("bp1", 16'h0006, 1, 0, 0, 0, 0);
      send(16'h0001, 16'h0001, 0, 1, 0, 0, "bp2"); res("bp2", 16'h0002, 2, 1, 0, 0, 0);

      // Overflow: five words on a WORDS=4 sequencer. The carry chains through every word.
      send(16'hFFFF, 16'h0001, 1, 0, 0, 0, "ov0"); res("ov0", 16'h0000, 0, 0, 1, 0, 0);
      send(16'hFFFF, 16'h0000, 0, 0, 0, 1, "ov1"); res("ov1", 16'h0000, 1, 0, 1, 0, 0);
      send(16'hFFFF, 16'h0000, 0, 0, 0, 1, "ov2"); res("ov2", 16'h0000, 2, 0, 1, 0, 0);
      send(16'hFFFF, 16'h0000, 0, 0, 0, 1, "ov3"); res("ov3", 16'h0000, 3, 0, 1, 0, 0);
      send(16'hFFFF, 16'h0000, 0, 1, 0, 1, "ov4"); res("ov4", 16'h0000, 3, 1, 1, 1, 0);

      // A mid-frame in_first restarts the chain, so the stale carry is not applied.
      send(16'hFFFF, 16'h0001, 1, 0, 0, 0, "sq0"); res("sq0", 16'h0000, 0, 0, 1, 0, 0);
      send(16'h0001, 16'h0001, 1, 1, 0, 0, "sq1"); res("sq1", 16'h0002, 0, 1, 0, 0, 1);

      // Reset mid-frame. The next word is treated as first even though in_first=0.
      send(16'hFFFF, 16'h0001, 1, 0, 0, 0, "rm0"); res("rm0", 16'h0000, 0, 0, 1, 0, 0);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      chk("rm_valid", 32'(out_valid), 0);
      send(16'h0001, 16'h0001, 0, 1, 0, 0, "rm1"); res("rm1", 16'h0002, 0, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guards against a hang caused by a broken handshake.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/add_word_sequencer.md
Name: add_word_sequencer

Overview:
- Multi-precision add/subtract sequencer that sits directly upstream of the n-bit ripple-carry adder.
- It accepts wide operands as a stream of N-bit words, least-significant word first, over a valid/ready handshake.
- It drives the adder's carry-in, X and Y each cycle, chains the adder's carry-out between words in a register, and emits registered result words downstream.
- Typical use: 64-bit add/sub built from the 16-bit adder over 4 cycles.

Parameters:
- N, 16, word width; must equal the adder's n.
- WORDS, 4, maximum words per frame; index width is clog2(WORDS), minimum 1.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_x  in  N  operand X word.
- in_y  in  N  operand Y word.
- in_first  in  1  word is least-significant word of a new frame.
- in_last  in  1  word is most-significant word of the frame.
- in_sub  in  1  frame is X - Y; sampled only on the first word.
- add_carryin  out  1  to adder carryin.
- add_X  out  N  to adder X.
- add_Y  out  N  to adder Y.
- add_S  in  N  from adder S; combinational, same cycle.
- add_carryout  in  1  from adder carryout.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts result.
- out_s  out  N  result word.
- out_idx  out  clog2(WORDS)  word index within frame, 0 = LSW.
- out_last  out  1  result word is the frame's MSW.
- out_carry  out  1  final carry-out; meaningful only when out_last=1; 0 on a subtract means borrow.
- frame_err  out  1  one-word flag: frame exceeded WORDS words.
- seq_err  out  1  one-word flag: in_first seen mid-frame.

Behaviour:
- Reset (synchronous, Reset=1 at a rising edge): out_valid=0, out_s=0, out_idx=0, out_last=0, out_carry=0, frame_err=0, seq_err=0. Internal: carry_q=0, sub_q=0, idx_q=0, state=IDLE. Reset mid-frame discards the frame; the next accepted word starts a fresh frame.
- States and transitions:
  - IDLE = awaiting first word. An accepted word with in_last=0 goes to ACTIVE; with in_last=1 it stays in IDLE.
  - ACTIVE = mid-frame. An accepted word with in_last=1 returns to IDLE.
- First word: a word accepted in IDLE is a first word even if in_first=0. A word accepted in ACTIVE with in_first=1 is also a first word, and sets seq_err=1 on that output word.
- Adder drive (combinational, every cycle):
  - add_X = in_x.
  - add_Y = eff_sub ? ~in_y : in_y, where eff_sub = first ? in_sub : sub_q.
  - add_carryin = first ? in_sub : carry_q.
- On accept (registered, 1-cycle latency):
  - out_s <= add_S; out_carry <= add_carryout; carry_q <= add_carryout.
  - out_last <= in_last; out_valid <= 1.
  - out_idx <= first ? 0 : idx_q+1, saturating at WORDS-1.
  - On a first word, sub_q <= in_sub.
  - frame_err <= 1 if the word is non-first and idx_q == WORDS-1, else 0. The frame continues with its carry chain intact.
  - seq_err <= 1 only as described above, else 0.
- Handshake: single output register. in_ready = !out_valid || out_ready.
  - Output holds stable while out_valid && !out_ready.
  - out_valid drops after the handshake if no new word is accepted in the same cycle.
  - Simultaneous out-handshake and in-accept gives full throughput, one word per cycle.
- No accept: carry_q, sub_q, idx_q and state hold; adder outputs are ignored.

Test Plan:
- Add, 2 words, X=0x0001_FFFF, Y=0x0000_0001 -> out (s=0x0000, idx0, carry1), then (s=0x0002, idx1, last=1, out_carry=0).
- Subtract, 2 words, X=0x0000_0000, Y=0x0000_0001 -> out_s 0xFFFF, 0xFFFF; out_carry=0 (borrow). X=5, Y=3 -> out_s 0x0002, 0x0000; out_carry=1.
- Backpressure: out_ready=0 for 3 cycles mid-frame -> in_ready=0, out_s/out_idx stable, carry_q unchanged. Releasing it gives a correct continued sum and one word per cycle thereafter.
- Overflow: WORDS=4, 5-word frame of 0xFFFF + 0x0000 with carry-in 1 via first-word chaining -> frame_err=1 only on the 5th word, out_idx=3 there.
- Mid-frame in_first: word0 0xFFFF+0x0001 (carry1), then in_first=1 word 0x0001+0x0001 -> seq_err=1, out_s=0x0002 (stale carry not applied), out_idx=0.
- Reset asserted after word0 of a 4-word frame -> next cycle out_valid=0. A following word with in_first=0 is treated as first: carry_in=in_sub, out_idx=0.
